// File: rtl/rca2_pkg.sv
// Shared types and constants for the 4-bit RCA double-fault output response analyser.
package rca2_pkg;

    localparam int WIDTH = 4;
    localparam int NPAT  = 8;
    localparam int CW    = $clog2(NPAT);
    localparam int SW    = WIDTH + 1;

    localparam logic [SW-1:0] MISR_SEED  = 5'h1F;
    localparam logic [SW-1:0] MISR_POLY  = 5'h05;
    // Signature left behind by a fault-free sweep of the standard 8-pattern set
    localparam logic [SW-1:0] GOLDEN_SIG = 5'h18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [SW-1:0] misr_next(input logic [SW-1:0] s, input logic [SW-1:0] d);
        return {s[SW-2:0], 1'b0} ^ (s[SW-1] ? MISR_POLY : '0) ^ d;
    endfunction

endpackage

// File: rtl/rca2_misr.sv
// 5-bit multiple-input signature register; load_seed and shift together seed then compact once.
module rca2_misr
    import rca2_pkg::*;
(
    input  logic          clk,
    input  logic          init,
    input  logic          load_seed,
    input  logic          shift,
    input  logic [SW-1:0] din,
    output logic [SW-1:0] sig
);

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            sig <= MISR_SEED;
        end else if (shift) begin
            sig <= misr_next(load_seed ? MISR_SEED : sig, din);
        end else if (load_seed) begin
            sig <= MISR_SEED;
        end
    end

endmodule

// File: rtl/rca2_ora.sv
// Output response analyser: compares adder results per pattern, logs failures and
// compacts responses into a MISR signature over one 8-pattern sweep.
module rca2_ora
    import rca2_pkg::*;
(
    input  logic             clk,
    input  logic             init,
    input  logic             test,
    input  logic [CW-1:0]    count,
    input  logic [WIDTH-1:0] at,
    input  logic [WIDTH-1:0] bt,
    input  logic             cint,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             done,
    output logic             pass,
    output logic [NPAT-1:0]  fail_map,
    output logic [CW:0]      fail_cnt,
    output logic [CW-1:0]    first_fail,
    output logic             seq_err,
    output logic [SW-1:0]    signature
);

    localparam logic [CW:0]   CNT_MAX = (CW+1)'(NPAT);
    localparam logic [CW:0]   CNT_ONE = (CW+1)'(1);
    localparam logic [CW-1:0] IDX_ONE = CW'(1);
    localparam logic [CW-1:0] IDX_LST = CW'(NPAT - 1);

    state_t          state;
    logic [CW-1:0]   exp_idx;
    logic [NPAT-1:0] seen;

    logic [SW-1:0]   exp_val;
    logic [SW-1:0]   resp;
    logic            miscmp;
    logic            start;
    logic            abort;
    logic            sample;
    logic            last;

    logic [NPAT-1:0] fm_n;
    logic [CW:0]     fc_n;
    logic [CW-1:0]   ff_n;
    logic            se_n;
    logic [NPAT-1:0] seen_n;

    assign exp_val = {1'b0, at} + {1'b0, bt} + {{WIDTH{1'b0}}, cint};
    assign resp    = {cout, sum};
    assign miscmp  = (resp != exp_val);

    assign start  = (state == IDLE) && test && (count == '0);
    assign abort  = (state == RUN) && !test;
    assign sample = start || ((state == RUN) && test);
    assign last   = (exp_idx == IDX_LST);

    // Log values the current sample would produce; a repeated index only flags seq_err
    always_comb begin
        fm_n   = fail_map;
        fc_n   = fail_cnt;
        ff_n   = first_fail;
        seen_n = seen;
        se_n   = seq_err || (count != exp_idx) || seen[count];
        if (!seen[count]) begin
            seen_n[count] = 1'b1;
            if (miscmp) begin
                fm_n[count] = 1'b1;
                if (fail_cnt != CNT_MAX) begin
                    fc_n = fail_cnt + CNT_ONE;
                end
                if (fail_cnt == '0) begin
                    ff_n = count;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state      <= IDLE;
            exp_idx    <= '0;
            seen       <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_map   <= '0;
            fail_cnt   <= '0;
            first_fail <= '0;
            seq_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        fail_map   <= fm_n;
                        fail_cnt   <= fc_n;
                        first_fail <= ff_n;
                        seq_err    <= se_n;
                        seen       <= seen_n;
                        exp_idx    <= IDX_ONE;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (!test) begin
                        state      <= IDLE;
                        exp_idx    <= '0;
                        seen       <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail_map   <= '0;
                        fail_cnt   <= '0;
                        first_fail <= '0;
                        seq_err    <= 1'b0;
                    end else begin
                        fail_map   <= fm_n;
                        fail_cnt   <= fc_n;
                        first_fail <= ff_n;
                        seq_err    <= se_n;
                        seen       <= seen_n;
                        exp_idx    <= exp_idx + IDX_ONE;
                        if (last) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= (fm_n == '0) && !se_n;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    rca2_misr u_misr (
        .clk       (clk),
        .init      (init),
        .load_seed (start || abort),
        .shift     (sample),
        .din       (resp),
        .sig       (signature)
    );

endmodule

// File: tb/tb_rca2_ora.sv
// Self-checking bench for rca2_ora: the bench plays pattern generator plus (faulty) adder
// and checks every output against a sweep-level reference model after each clock.
module tb_rca2_ora;
    import rca2_pkg::*;

    logic       clk = 1'b0;
    logic       init;
    logic       test;
    logic [2:0] count;
    logic [3:0] at, bt, sum;
    logic       cint, cout;
    logic       done, pass, seq_err;
    logic [7:0] fail_map;
    logic [3:0] fail_cnt;
    logic [2:0] first_fail;
    logic [4:0] signature;

    int tests = 0;
    int fails = 0;

    // injected adder faults
    logic [3:0] sa0 = '0, sa1 = '0;
    bit         coutSa0 = 0, coutSa1 = 0;

    logic [3:0] da [8] = '{4'hA, 4'hA, 4'h5, 4'h5, 4'h0, 4'h0, 4'hF, 4'hF};
    logic [3:0] db [8] = '{4'hA, 4'h5, 4'hA, 4'h5, 4'h0, 4'hF, 4'h0, 4'hF};
    logic       dci[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // reference model state
    bit         mRun, mDone, mSe;
    int         mN, mFc;
    logic [7:0] mFm, mSeen;
    logic [2:0] mFf;
    logic [4:0] mSig;

    rca2_ora dut (
        .clk(clk), .init(init), .test(test), .count(count), .at(at), .bt(bt),
        .cint(cint), .sum(sum), .cout(cout), .done(done), .pass(pass),
        .fail_map(fail_map), .fail_cnt(fail_cnt), .first_fail(first_fail),
        .seq_err(seq_err), .signature(signature)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        if (obs !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic modelReset();
        mRun = 0; mDone = 0; mSe = 0; mN = 0; mFc = 0;
        mFm = '0; mSeen = '0; mFf = '0; mSig = 5'h1F;
    endtask

    // Signature as polynomial arithmetic: multiply by x modulo x^5+x^2+1, then add response
    function automatic logic [4:0] misrModel(input logic [4:0] s, input logic [4:0] d);
        logic [5:0] t;
        t = {s, 1'b0};
        if (t[5]) t = t ^ 6'b100101;
        return t[4:0] ^ d;
    endfunction

    task automatic modelLog(input logic [2:0] c, input logic [4:0] resp, input logic [4:0] expv);
        if (int'(c) != mN || mSeen[c]) mSe = 1;
        if (!mSeen[c]) begin
            mSeen[c] = 1'b1;
            if (resp != expv) begin
                if (mFc == 0) mFf = c;
                mFc = (mFc < 8) ? mFc + 1 : 8;
                mFm[c] = 1'b1;
            end
        end
        mSig = misrModel(mSig, resp);
    endtask

    task automatic modelStep(input bit t, input logic [2:0] c, input logic [4:0] resp, input logic [4:0] expv);
        if (mDone) begin
        end else if (!mRun) begin
            if (t && c == 3'd0) begin
                mN = 0;
                modelLog(c, resp, expv);
                mN = 1;
                mRun = 1;
            end
        end else if (!t) begin
            modelReset();
        end else begin
            modelLog(c, resp, expv);
            if (mN == 7) begin
                mDone = 1;
                mRun = 0;
            end
            mN++;
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".done"}, 32'(done), 32'(mDone));
        checkOutput({tag, ".pass"}, 32'(pass), 32'(mDone && mFm == 0 && !mSe));
        checkOutput({tag, ".fail_map"}, 32'(fail_map), 32'(mFm));
        checkOutput({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(mFc));
        checkOutput({tag, ".first_fail"}, 32'(first_fail), 32'(mFf));
        checkOutput({tag, ".seq_err"}, 32'(seq_err), 32'(mSe));
        checkOutput({tag, ".signature"}, 32'(signature), 32'(mSig));
    endtask

    // One clock: the bench's adder (with faults) responds to the operands it drives
    task automatic applyStimulus(input string tag, input bit t, input logic [2:0] c,
                                 input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [4:0] r;
        @(negedge clk);
        r = 5'(a) + 5'(b) + 5'(ci);
        test = t; count = c; at = a; bt = b; cint = ci;
        sum  = (r[3:0] & ~sa0) | sa1;
        cout = coutSa1 ? 1'b1 : (coutSa0 ? 1'b0 : r[4]);
        @(posedge clk);
        #1;
        modelStep(t, c, {cout, sum}, r);
        compareAll(tag);
    endtask

    task automatic asyncInit(input string tag);
        @(negedge clk);
        test = 1'b0;
        #1 init = 1'b1;
        #1;
        modelReset();
        compareAll(tag);
        #1 init = 1'b0;
    endtask

    // abortAt: drop test on that sample; skipFrom: jump count by two after it; stopAt: leave early
    task automatic runSweep(input string tag, input bit dir, input int abortAt,
                            input int skipFrom, input int stopAt);
        logic [2:0] c;
        logic [3:0] a, b;
        logic       ci;
        c = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (i == stopAt) return;
            if (dir) begin
                a = da[i]; b = db[i]; ci = dci[i];
            end else begin
                a = 4'($urandom); b = 4'($urandom); ci = 1'($urandom);
            end
            if (i == abortAt) begin
                applyStimulus(tag, 1'b0, c, a, b, ci);
                return;
            end
            applyStimulus(tag, 1'b1, c, a, b, ci);
            c = (i == skipFrom) ? c + 3'd2 : c + 3'd1;
        end
    endtask

    task automatic holdDone(input string tag);
        for (int k = 0; k < 2; k++)
            applyStimulus(tag, 1'($urandom), 3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic clearFaults();
        sa0 = '0; sa1 = '0; coutSa0 = 0; coutSa1 = 0;
    endtask

    initial begin
        init = 1'b1; test = 1'b0; count = '0; at = '0; bt = '0; cint = 1'b0;
        sum = '0; cout = 1'b0;
        modelReset();
        #12;
        compareAll("reset");
        @(negedge clk);
        init = 1'b0;

        runSweep("clean", 1, -1, -1, -1);
        checkOutput("golden_sig", 32'(signature), 32'h18);
        checkOutput("clean_pass", 32'(pass), 32'd1);
        holdDone("hold");
        asyncInit("init_done");

        sa1 = 4'b0100; coutSa0 = 1;
        runSweep("dbl", 1, -1, -1, -1);
        checkOutput("dbl_pass", 32'(pass), 32'd0);
        asyncInit("init_dbl");
        clearFaults();

        sa0 = 4'b0001;
        runSweep("sgl", 1, -1, -1, -1);
        asyncInit("init_sgl");
        clearFaults();

        runSweep("abort", 1, 4, -1, -1);
        applyStimulus("abort_idle", 1'b0, 3'd5, 4'h3, 4'h4, 1'b0);
        runSweep("reclean", 1, -1, -1, -1);
        checkOutput("reclean_pass", 32'(pass), 32'd1);
        asyncInit("init_re");

        runSweep("skip", 1, -1, 2, -1);
        checkOutput("skip_seq", 32'(seq_err), 32'd1);
        asyncInit("init_skip");

        runSweep("abort7", 1, 7, -1, -1);
        checkOutput("abort7_done", 32'(done), 32'd0);

        for (int k = 0; k < 3; k++)
            applyStimulus("nostart", 1'b1, 3'(k + 3), 4'($urandom), 4'($urandom), 1'b0);

        runSweep("midrun", 0, -1, -1, 5);
        asyncInit("init_run");

        for (int s = 0; s < 24; s++) begin
            sa0 = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            sa1 = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            coutSa0 = ($urandom_range(0, 3) == 0);
            coutSa1 = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 4))
                0:       runSweep("rnd_abort", 0, $urandom_range(1, 7), -1, -1);
                1:       runSweep("rnd_skip", 0, -1, $urandom_range(0, 6), -1);
                2:       runSweep("rnd_stop", 0, -1, -1, $urandom_range(1, 7));
                default: runSweep("rnd", 0, -1, -1, -1);
            endcase
            holdDone("rnd_hold");
            asyncInit("rnd_init");
        end
        clearFaults();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
